awg_param_ctrl: RTL and testbench

//  Front-panel parameter controller upstream of the sine generator stage.
//  - Synchronises and debounces 7 active-low push-buttons, with auto-repeat.
//  - Holds the registered waveform settings: en, state_freq, state_amp, state_phase.
//  - These outputs drive the generator's en / state_freq / state_amp / state_phase inputs directly.

---
 rtl/awg_param_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_awg_param_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/awg_param_ctrl.sv
// ----------------------------------------------------------------------------
// awg_param_ctrl
//   Front-panel parameter controller for the sine generator. It synchronises
//   and debounces seven active-low push-buttons, generates press events with
//   auto-repeat on the frequency and phase keys, and keeps the registered
//   waveform settings that feed the generator.
//
// Ports
//   clk          in   1   system clock, all logic on posedge
//   rst_n        in   1   asynchronous active-low reset
//   key_n        in   7   raw buttons, active-low, asynchronous
//                         [0]f_up [1]f_dn [2]a_up [3]a_dn [4]p_up [5]p_dn
//                         [6]en_toggle
//   en           out  1   generator enable
//   state_freq   out  12  phase-accumulator step, never 0
//   state_amp    out  3   amplitude divisor, 1..7
//   state_phase  out  8   phase offset
//   param_upd    out  1   one-cycle pulse when any output value changes
// ----------------------------------------------------------------------------
module awg_param_ctrl #(
    parameter logic [19:0] DEBOUNCE_CYC   = 20'd1_000_000,
    parameter logic [24:0] REPEAT_DLY_CYC = 25'd25_000_000,
    parameter logic [22:0] REPEAT_CYC     = 23'd5_000_000,
    parameter logic [11:0] FREQ_RST       = 12'd64,
    parameter logic [11:0] FREQ_STEP      = 12'd16,
    parameter logic [7:0]  PHASE_STEP     = 8'd8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  key_n,
    output logic        en,
    output logic [11:0] state_freq,
    output logic [2:0]  state_amp,
    output logic [7:0]  state_phase,
    output logic        param_upd
);

    localparam logic [19:0] DB_LAST    = DEBOUNCE_CYC - 20'd1;
    localparam logic [24:0] DLY_LAST   = REPEAT_DLY_CYC - 25'd1;
    // Reload value after a repeat so the next one lands REPEAT_CYC later.
    localparam logic [24:0] RPT_RELOAD = REPEAT_DLY_CYC - {2'b00, REPEAT_CYC};

    // Hold counter j serves key 0,1,4,5 respectively.
    function automatic int unsigned rpt_key(input int unsigned j);
        return (j < 2) ? j : j + 2;
    endfunction

    logic [6:0]  sync1_q, sync2_q;
    logic [6:0]  deb_q, deb_d;
    logic [6:0]  arm_q, arm_d;
    logic [19:0] db_cnt_q [7];
    logic [19:0] db_cnt_d [7];
    logic [24:0] hold_q [4];
    logic [24:0] hold_d [4];
    logic [6:0]  press;
    logic [6:0]  ev_q, ev_d;

    logic        en_q, en_d;
    logic [11:0] freq_q, freq_d;
    logic [2:0]  amp_q, amp_d;
    logic [7:0]  phase_q, phase_d;
    logic        upd_q, upd_d;

    logic [12:0] freq_sum;
    logic        f_up, f_dn, a_up, a_dn, p_up, p_dn;

    // Debounce. A key is "unarmed" after reset: its debounced level stays
    // released and the counter instead measures a stable released window.
    // Only once that window completes can the key produce a press, so a key
    // held through reset deassertion stays silent until let go.
    always_comb begin
        deb_d    = deb_q;
        arm_d    = arm_q;
        db_cnt_d = db_cnt_q;
        for (int unsigned i = 0; i < 7; i++) begin
            if (!arm_q[i]) begin
                if (sync2_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        arm_d[i]    = 1'b1;
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + 20'd1;
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end else if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    deb_d[i]    = sync2_q[i];
                    db_cnt_d[i] = '0;
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 20'd1;
                end
            end else begin
                db_cnt_d[i] = '0;
            end
        end
    end

    assign press = deb_q & ~deb_d;

    // Press and auto-repeat events, registered so outputs follow one cycle later.
    always_comb begin
        ev_d   = press;
        hold_d = hold_q;
        for (int unsigned j = 0; j < 4; j++) begin
            if (press[rpt_key(j)]) begin
                hold_d[j] = '0;
            end else if (!deb_q[rpt_key(j)] && !deb_d[rpt_key(j)]) begin
                if (hold_q[j] == DLY_LAST) begin
                    ev_d[rpt_key(j)] = 1'b1;
                    hold_d[j]        = RPT_RELOAD;
                end else begin
                    hold_d[j] = hold_q[j] + 25'd1;
                end
            end else begin
                hold_d[j] = '0;
            end
        end
    end

    // Opposing events on one parameter cancel each other.
    assign f_up = ev_q[0] & ~ev_q[1];
    assign f_dn = ev_q[1] & ~ev_q[0];
    assign a_up = ev_q[2] & ~ev_q[3];
    assign a_dn = ev_q[3] & ~ev_q[2];
    assign p_up = ev_q[4] & ~ev_q[5];
    assign p_dn = ev_q[5] & ~ev_q[4];

    assign freq_sum = {1'b0, freq_q} + {1'b0, FREQ_STEP};

    always_comb begin
        en_d    = en_q;
        freq_d  = freq_q;
        amp_d   = amp_q;
        phase_d = phase_q;

        if (ev_q[6]) begin
            en_d = ~en_q;
        end

        if (f_up) begin
            freq_d = freq_sum[12] ? 12'hFFF : freq_sum[11:0];
        end else if (f_dn) begin
            freq_d = (freq_q > FREQ_STEP) ? (freq_q - FREQ_STEP) : 12'd1;
        end

        // a_up gives a larger output, i.e. a smaller divisor.
        if (a_up) begin
            amp_d = (amp_q > 3'd1) ? (amp_q - 3'd1) : 3'd1;
        end else if (a_dn) begin
            amp_d = (amp_q < 3'd7) ? (amp_q + 3'd1) : 3'd7;
        end

        if (p_up) begin
            phase_d = phase_q + PHASE_STEP;
        end else if (p_dn) begin
            phase_d = phase_q - PHASE_STEP;
        end

        upd_d = (en_d != en_q) || (freq_d != freq_q) ||
                (amp_d != amp_q) || (phase_d != phase_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '1;
            sync2_q <= '1;
            deb_q   <= '1;
            arm_q   <= '0;
            ev_q    <= '0;
            for (int unsigned i = 0; i < 7; i++) begin
                db_cnt_q[i] <= '0;
            end
            for (int unsigned j = 0; j < 4; j++) begin
                hold_q[j] <= '0;
            end
            en_q    <= 1'b0;
            freq_q  <= FREQ_RST;
            amp_q   <= 3'd1;
            phase_q <= '0;
            upd_q   <= 1'b0;
        end else begin
            sync1_q  <= key_n;
            sync2_q  <= sync1_q;
            deb_q    <= deb_d;
            arm_q    <= arm_d;
            ev_q     <= ev_d;
            db_cnt_q <= db_cnt_d;
            hold_q   <= hold_d;
            en_q     <= en_d;
            freq_q   <= freq_d;
            amp_q    <= amp_d;
            phase_q  <= phase_d;
            upd_q    <= upd_d;
        end
    end

    assign en          = en_q;
    assign state_freq  = freq_q;
    assign state_amp   = amp_q;
    assign state_phase = phase_q;
    assign param_upd   = upd_q;

endmodule

// File: tb/tb_awg_param_ctrl.sv
// ----------------------------------------------------------------------------
// tb_awg_param_ctrl
//   Directed and randomized bench for awg_param_ctrl with short debounce and
//   repeat timings. Expected outputs come from a parameter model driven by
//   the key-event schedule (press output 7 cycles after the edge, repeats at
//   +20 then every +5 while held).
// ----------------------------------------------------------------------------
module tb_awg_param_ctrl;

    localparam int LAT     = 7;    // 2 sync + 4 debounce + 1 output register
    localparam int RPT_DLY = 20;
    localparam int RPT     = 5;
    localparam int DB      = 4;
    localparam logic [6:0] REP_KEYS = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  key_n;
    logic        en;
    logic [11:0] state_freq;
    logic [2:0]  state_amp;
    logic [7:0]  state_phase;
    logic        param_upd;

    int n_assert = 0;
    int n_fail   = 0;

    int m_en, m_freq, m_amp, m_phase, m_upd;

    awg_param_ctrl #(
        .DEBOUNCE_CYC   (20'd4),
        .REPEAT_DLY_CYC (25'd20),
        .REPEAT_CYC     (23'd5),
        .FREQ_RST       (12'd64),
        .FREQ_STEP      (12'd16),
        .PHASE_STEP     (8'd8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .en          (en),
        .state_freq  (state_freq),
        .state_amp   (state_amp),
        .state_phase (state_phase),
        .param_upd   (param_upd)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_en"},    int'(en),          m_en);
        chk({tag, "_freq"},  int'(state_freq),  m_freq);
        chk({tag, "_amp"},   int'(state_amp),   m_amp);
        chk({tag, "_phase"}, int'(state_phase), m_phase);
        chk({tag, "_upd"},   int'(param_upd),   m_upd);
    endtask

    task automatic model_reset();
        m_en = 0; m_freq = 64; m_amp = 1; m_phase = 0; m_upd = 0;
    endtask

    // Apply one simultaneous set of key events to the parameter model.
    task automatic apply(input logic [6:0] m);
        int of, oa, op, oe;
        of = m_freq; oa = m_amp; op = m_phase; oe = m_en;
        if (m[0] && !m[1]) m_freq = (m_freq + 16 > 4095) ? 4095 : m_freq + 16;
        if (m[1] && !m[0]) m_freq = (m_freq - 16 < 1) ? 1 : m_freq - 16;
        if (m[2] && !m[3]) m_amp = (m_amp > 1) ? m_amp - 1 : 1;
        if (m[3] && !m[2]) m_amp = (m_amp < 7) ? m_amp + 1 : 7;
        if (m[4] && !m[5]) m_phase = (m_phase + 8) % 256;
        if (m[5] && !m[4]) m_phase = (m_phase + 256 - 8) % 256;
        if (m[6]) m_en = 1 - m_en;
        m_upd = (of != m_freq || oa != m_amp || op != m_phase || oe != m_en) ? 1 : 0;
    endtask

    // Press the keys in mask cleanly, hold for n cycles, then release;
    // outputs are checked every cycle for total cycles.
    task automatic drive_hold(input logic [6:0] mask, input int n, input int total,
                              input string tag);
        key_n = ~mask;
        for (int k = 1; k <= total; k++) begin
            step();
            m_upd = 0;
            if (k == LAT)
                apply(mask);
            else if (k >= LAT + RPT_DLY && ((k - LAT - RPT_DLY) % RPT) == 0 && k <= n + 2 + DB)
                apply(mask & REP_KEYS);
            check_all(tag);
            if (k == n) key_n = '1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        key_n = '1;
        model_reset();
        step();
        step();
        check_all("reset");
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_all("idle");
        end

        // 1: clean f_up press, 64 -> 80 after exactly 7 cycles
        drive_hold(7'h01, 8, 18, "t1_fup");

        // 2: bouncing en key, then a steady hold toggles en once
        key_n = 7'h3F;
        for (int k = 1; k <= 44; k++) begin
            step();
            m_upd = 0;
            if (k == 20 + LAT) apply(7'h40);
            check_all("t2_bounce");
            if (k < 20)
                key_n = (((k / 2) % 2) == 0) ? 7'h3F : 7'h7F;
            else if (k < 30)
                key_n = 7'h3F;
            else
                key_n = '1;
        end

        // 3: back to 64, then hold f_dn for 40 cycles -> 48,32,16,1,1
        drive_hold(7'h02, 8, 18, "t3_pre");
        drive_hold(7'h02, 40, 50, "t3_hold");

        // 4: amp ceiling and floor
        for (int i = 0; i < 8; i++) drive_hold(7'h08, 8, 18, "t4_adn");
        for (int i = 0; i < 7; i++) drive_hold(7'h04, 8, 18, "t4_aup");

        // 5: opposing phase keys cancel; p_dn wraps 0 -> 248
        drive_hold(7'h30, 8, 18, "t5_both");
        drive_hold(7'h20, 8, 18, "t5_pdn");

        // Random key combinations and hold lengths
        for (int r = 0; r < 25; r++) begin
            logic [6:0] mask;
            int n;
            mask = 7'($urandom_range(0, 127));
            n    = int'($urandom_range(8, 40));
            drive_hold(mask, n, n + 10, "rand");
        end

        // Long f_up hold into the 4095 ceiling
        drive_hold(7'h01, 1400, 1410, "fsat");

        // 6: reset in the middle of an f_up hold
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst_a");
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_all("t6_idle");
        end
        drive_hold(7'h01, 8, 18, "t6_pre");
        key_n = 7'h7E;
        for (int k = 1; k <= 15; k++) begin
            step();
            m_upd = 0;
            if (k == LAT) apply(7'h01);
            check_all("t6_hold");
        end
        chk("t6_freq96", int'(state_freq), 96);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("t6_rst_b");
        for (int k = 0; k < 3; k++) begin
            step();
            check_all("t6_in_rst");
        end
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            check_all("t6_held");
        end
        key_n = '1;
        for (int k = 0; k < 20; k++) begin
            step();
            check_all("t6_rel");
        end
        drive_hold(7'h01, 8, 18, "t6_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
